// File: rtl/outlier_column_gather.sv
// Streaming per-column outlier detector: flags columns where any |x| exceeds THRES over a tile.
// Mask valid one cycle after the last-beat handshake; the last beat stalls only while an undrained mask is held.
module outlier_column_gather #(
    parameter int            IN_WIDTH       = 16,
    parameter int            IN_SIZE        = 4,
    parameter int            IN_PARALLELISM = 1,
    parameter int            NUM_ROWS       = 4,
    parameter logic [IN_WIDTH-1:0] THRES    = 16'h4F80,
    parameter bit            INCLUSIVE      = 1'b0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_in,
    input  logic                                           data_in_valid,
    output logic                                           data_in_ready,
    output logic [IN_SIZE-1:0]                             data_out,
    output logic [$clog2(IN_SIZE+1)-1:0]                   data_out_count,
    output logic                                           data_out_valid,
    input  logic                                           data_out_ready
);

    localparam int DEPTH = NUM_ROWS / IN_PARALLELISM;
    localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCW   = $clog2(IN_SIZE + 1);
    localparam int NE    = IN_SIZE * IN_PARALLELISM;
    localparam logic [IN_WIDTH-2:0] THR_MAG = THRES[IN_WIDTH-2:0];
    localparam logic [CW-1:0]       LAST_CNT = CW'(DEPTH - 1);

    logic [IN_SIZE-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IN_SIZE-1:0] mask_q, mask_d;
    logic [OCW-1:0]     count_q, count_d;
    logic               valid_q, valid_d;

    logic [IN_SIZE-1:0] beat_flag;
    logic [IN_SIZE-1:0] tile_mask;
    logic               last_beat;
    logic               in_hs;
    logic               out_hs;

    // Sign bits are intentionally ignored: only magnitude matters.
    logic [NE-1:0]      unused_sign_bits;

    function automatic logic is_outlier(input logic [IN_WIDTH-2:0] mag);
        if (INCLUSIVE)
            return mag >= THR_MAG;
        else
            return mag > THR_MAG;
    endfunction

    function automatic logic [OCW-1:0] popcount(input logic [IN_SIZE-1:0] m);
        logic [OCW-1:0] sum;
        sum = '0;
        for (int i = 0; i < IN_SIZE; i++)
            sum = sum + OCW'(m[i]);
        return sum;
    endfunction

    always_comb begin
        beat_flag        = '0;
        unused_sign_bits = '0;
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            for (int c = 0; c < IN_SIZE; c++) begin
                beat_flag[c] = beat_flag[c] | is_outlier(data_in[r*IN_SIZE+c][IN_WIDTH-2:0]);
                unused_sign_bits[r*IN_SIZE+c] = data_in[r*IN_SIZE+c][IN_WIDTH-1];
            end
        end
    end

    assign last_beat     = (cnt_q == LAST_CNT);
    assign tile_mask     = acc_q | beat_flag;
    assign data_in_ready = rst && (!last_beat || !valid_q || data_out_ready);
    assign in_hs         = data_in_valid && data_in_ready;
    assign out_hs        = valid_q && data_out_ready;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        count_d = count_q;
        valid_d = valid_q;
        if (out_hs)
            valid_d = 1'b0;
        // A last beat landing in the same cycle as a drain reloads without a bubble.
        if (in_hs) begin
            if (last_beat) begin
                mask_d  = tile_mask;
                count_d = popcount(tile_mask);
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = tile_mask;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign data_out       = mask_q;
    assign data_out_count = count_q;
    assign data_out_valid = valid_q;

endmodule
